// File: rtl/fic0_ahb_pkg.sv
// Shared AHB-Lite codes, arbiter FSM states and the pending-request
// bundle used by the FIC_0 two-master arbiter.
package fic0_ahb_pkg;

    localparam int PEND_AW = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_t;

    typedef struct packed {
        logic [PEND_AW-1:0] addr;
        logic               write;
        logic [2:0]         size;
        logic [3:0]         prot;
        logic               lock;
    } pend_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request picker: lock holder first, then round-robin pointer
// (or fixed M1 priority when FIC0_ARB_FIXED_PRIORITY_EN is defined).
module rr_arb2
    import fic0_ahb_pkg::*;
(
`ifndef FIC0_ARB_FIXED_PRIORITY_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       take,
`endif
    input  logic [1:0] req,
    input  logic       lock_vld,
    input  logic       lock_id,
    output logic       any,
    output logic       gnt
);

    logic pref;

`ifdef FIC0_ARB_FIXED_PRIORITY_EN
    assign pref = 1'b1;
`else
    logic ptr_q;

    // Pointer names the requester favoured on the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else if (take) begin
            ptr_q <= ~gnt;
        end
    end

    assign pref = ptr_q;
`endif

    assign any = |req;

    always_comb begin
        gnt = 1'b0;
        if (lock_vld && req[lock_id]) begin
            gnt = lock_id;
        end else if (&req) begin
            gnt = pref;
        end else begin
            gnt = req[1];
        end
    end

endmodule

// File: rtl/fic0_ahb_arbiter.sv
// Shares the MSS FIC_0 AHB master port between M0 (fetch) and M1 (data).
// Build option: FIC0_ARB_FIXED_PRIORITY_EN gives M1 fixed priority.
module fic0_ahb_arbiter
    import fic0_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  FIC_0_CLK,
    input  logic                  FAB_RESET_N,
    input  logic [ADDR_WIDTH-1:0] M0_HADDR,
    input  logic [1:0]            M0_HTRANS,
    input  logic                  M0_HWRITE,
    input  logic [2:0]            M0_HSIZE,
    input  logic [2:0]            M0_HBURST,
    input  logic [3:0]            M0_HPROT,
    input  logic                  M0_HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] M0_HWDATA,
    output logic                  M0_HREADY,
    output logic [1:0]            M0_HRESP,
    output logic [DATA_WIDTH-1:0] M0_HRDATA,
    input  logic [ADDR_WIDTH-1:0] M1_HADDR,
    input  logic [1:0]            M1_HTRANS,
    input  logic                  M1_HWRITE,
    input  logic [2:0]            M1_HSIZE,
    input  logic [2:0]            M1_HBURST,
    input  logic [3:0]            M1_HPROT,
    input  logic                  M1_HMASTLOCK,
    input  logic [DATA_WIDTH-1:0] M1_HWDATA,
    output logic                  M1_HREADY,
    output logic [1:0]            M1_HRESP,
    output logic [DATA_WIDTH-1:0] M1_HRDATA,
    output logic [ADDR_WIDTH-1:0] S_HADDR,
    output logic [1:0]            S_HTRANS,
    output logic                  S_HWRITE,
    output logic [2:0]            S_HSIZE,
    output logic [2:0]            S_HBURST,
    output logic [3:0]            S_HPROT,
    output logic                  S_HMASTLOCK,
    output logic [DATA_WIDTH-1:0] S_HWDATA,
    input  logic                  S_HREADY,
    input  logic [1:0]            S_HRESP,
    input  logic [DATA_WIDTH-1:0] S_HRDATA
);

    logic clk;
    logic rst_n;

    assign clk   = FIC_0_CLK;
    assign rst_n = FAB_RESET_N;

    arb_state_t state_q, state_d;

    pend_t      pend_q [2];
    pend_t      cap    [2];
    logic [1:0] pend_vld_q;
    logic [1:0] m_hready;
    logic [1:0] cap_en;
    logic [1:0] clr_en;

    logic grant_q, grant_d;
    logic lock_vld_q, lock_id_q;
    logic arb_any, arb_gnt;
    logic take, done;

    logic [ADDR_WIDTH-1:0] s_haddr_q, s_haddr_d;
    logic [1:0]            s_htrans_q, s_htrans_d;
    logic                  s_hwrite_q, s_hwrite_d;
    logic [2:0]            s_hsize_q, s_hsize_d;
    logic [3:0]            s_hprot_q, s_hprot_d;
    logic                  s_hlock_q, s_hlock_d;

    logic unused_in;
    assign unused_in = ^{M0_HBURST, M1_HBURST, M0_HTRANS[0], M1_HTRANS[0]};

    always_comb begin
        cap[0] = '{addr:  PEND_AW'(M0_HADDR),
                   write: M0_HWRITE,
                   size:  M0_HSIZE,
                   prot:  M0_HPROT,
                   lock:  M0_HMASTLOCK};
        cap[1] = '{addr:  PEND_AW'(M1_HADDR),
                   write: M1_HWRITE,
                   size:  M1_HSIZE,
                   prot:  M1_HPROT,
                   lock:  M1_HMASTLOCK};
    end

    // A pending requester is stalled until its own MSS data phase ends.
    assign m_hready[0] = (state_q == DATA && !grant_q) ? S_HREADY : !pend_vld_q[0];
    assign m_hready[1] = (state_q == DATA &&  grant_q) ? S_HREADY : !pend_vld_q[1];

    assign cap_en = m_hready & {M1_HTRANS[1], M0_HTRANS[1]};
    assign clr_en = {done & grant_q, done & ~grant_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= '0;
            pend_q[0]  <= '0;
            pend_q[1]  <= '0;
        end else begin
            pend_vld_q <= cap_en | (pend_vld_q & ~clr_en);
            if (cap_en[0]) pend_q[0] <= cap[0];
            if (cap_en[1]) pend_q[1] <= cap[1];
        end
    end

    rr_arb2 u_arb (
`ifndef FIC0_ARB_FIXED_PRIORITY_EN
        .clk      (clk),
        .rst_n    (rst_n),
        .take     (take),
`endif
        .req      (pend_vld_q),
        .lock_vld (lock_vld_q),
        .lock_id  (lock_id_q),
        .any      (arb_any),
        .gnt      (arb_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            s_haddr_q  <= '0;
            s_htrans_q <= HTRANS_IDLE;
            s_hwrite_q <= 1'b0;
            s_hsize_q  <= '0;
            s_hprot_q  <= '0;
            s_hlock_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            s_haddr_q  <= s_haddr_d;
            s_htrans_q <= s_htrans_d;
            s_hwrite_q <= s_hwrite_d;
            s_hsize_q  <= s_hsize_d;
            s_hprot_q  <= s_hprot_d;
            s_hlock_q  <= s_hlock_d;
            if (done) begin
                lock_vld_q <= pend_q[grant_q].lock;
                lock_id_q  <= grant_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        s_haddr_d  = s_haddr_q;
        s_htrans_d = s_htrans_q;
        s_hwrite_d = s_hwrite_q;
        s_hsize_d  = s_hsize_q;
        s_hprot_d  = s_hprot_q;
        s_hlock_d  = s_hlock_q;
        take       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    take       = 1'b1;
                    grant_d    = arb_gnt;
                    state_d    = ADDR;
                    s_htrans_d = HTRANS_NONSEQ;
                    s_haddr_d  = ADDR_WIDTH'(pend_q[arb_gnt].addr);
                    s_hwrite_d = pend_q[arb_gnt].write;
                    s_hsize_d  = pend_q[arb_gnt].size;
                    s_hprot_d  = pend_q[arb_gnt].prot;
                    s_hlock_d  = pend_q[arb_gnt].lock;
                end
            end
            ADDR: begin
                if (S_HREADY) begin
                    state_d    = DATA;
                    s_htrans_d = HTRANS_IDLE;
                end
            end
            DATA: begin
                if (S_HREADY) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign S_HADDR     = s_haddr_q;
    assign S_HTRANS    = s_htrans_q;
    assign S_HWRITE    = s_hwrite_q;
    assign S_HSIZE     = s_hsize_q;
    assign S_HBURST    = HBURST_SINGLE;
    assign S_HPROT     = s_hprot_q;
    assign S_HMASTLOCK = s_hlock_q;
    assign S_HWDATA    = grant_q ? M1_HWDATA : M0_HWDATA;

    assign M0_HREADY = m_hready[0];
    assign M1_HREADY = m_hready[1];
    assign M0_HRESP  = (state_q == DATA && !grant_q) ? S_HRESP : HRESP_OKAY;
    assign M1_HRESP  = (state_q == DATA &&  grant_q) ? S_HRESP : HRESP_OKAY;
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;

endmodule

// File: tb/tb_fic0_ahb_arbiter.sv
// Bench for fic0_ahb_arbiter: two requester drivers, MSS slave model,
// and an in-order scoreboard of transfers seen on the MSS side.
module tb_fic0_ahb_arbiter;
    import fic0_ahb_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        lock;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [31:0] m_haddr  [2];
    logic [31:0] m_hwdata [2];
    logic [31:0] m_hrdata [2];
    logic [1:0]  m_htrans [2];
    logic [1:0]  m_hresp  [2];
    logic [2:0]  m_hsize  [2];
    logic [2:0]  m_hburst [2];
    logic [3:0]  m_hprot  [2];
    logic [1:0]  m_hwrite;
    logic [1:0]  m_hlock;
    logic [1:0]  m_hready;

    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic [1:0]  s_htrans, s_hresp;
    logic        s_hwrite, s_hlock, s_hready;
    logic [2:0]  s_hsize, s_hburst;
    logic [3:0]  s_hprot;

    logic        slv_fixed_en;
    logic [31:0] slv_fixed;
    logic        dp_act, dp_wr, dp_lock;
    logic [31:0] dp_addr;

    xfer_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fic0_ahb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .FIC_0_CLK    (clk),
        .FAB_RESET_N  (rst_n),
        .M0_HADDR     (m_haddr[0]),
        .M0_HTRANS    (m_htrans[0]),
        .M0_HWRITE    (m_hwrite[0]),
        .M0_HSIZE     (m_hsize[0]),
        .M0_HBURST    (m_hburst[0]),
        .M0_HPROT     (m_hprot[0]),
        .M0_HMASTLOCK (m_hlock[0]),
        .M0_HWDATA    (m_hwdata[0]),
        .M0_HREADY    (m_hready[0]),
        .M0_HRESP     (m_hresp[0]),
        .M0_HRDATA    (m_hrdata[0]),
        .M1_HADDR     (m_haddr[1]),
        .M1_HTRANS    (m_htrans[1]),
        .M1_HWRITE    (m_hwrite[1]),
        .M1_HSIZE     (m_hsize[1]),
        .M1_HBURST    (m_hburst[1]),
        .M1_HPROT     (m_hprot[1]),
        .M1_HMASTLOCK (m_hlock[1]),
        .M1_HWDATA    (m_hwdata[1]),
        .M1_HREADY    (m_hready[1]),
        .M1_HRESP     (m_hresp[1]),
        .M1_HRDATA    (m_hrdata[1]),
        .S_HADDR      (s_haddr),
        .S_HTRANS     (s_htrans),
        .S_HWRITE     (s_hwrite),
        .S_HSIZE      (s_hsize),
        .S_HBURST     (s_hburst),
        .S_HPROT      (s_hprot),
        .S_HMASTLOCK  (s_hlock),
        .S_HWDATA     (s_hwdata),
        .S_HREADY     (s_hready),
        .S_HRESP      (s_hresp),
        .S_HRDATA     (s_hrdata)
    );

    // MSS slave: tracks its own data phase; read data is ~address unless fixed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_act <= 1'b0;
        end else if (s_hready) begin
            dp_act  <= s_htrans[1];
            dp_addr <= s_haddr;
            dp_wr   <= s_hwrite;
            dp_lock <= s_hlock;
        end
    end

    assign s_hrdata = slv_fixed_en ? slv_fixed : ~dp_addr;

    // Scoreboard: every completed MSS transfer must match the next expected one.
    always @(negedge clk) begin
        xfer_t e;
        if (rst_n && dp_act && s_hready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got addr=%h wr=%b, required no transfer", dp_addr, dp_wr);
            end else begin
                e = sb.pop_front();
                if (dp_addr !== e.addr || dp_wr !== e.wr || dp_lock !== e.lock ||
                    (e.wr && s_hwdata !== e.wdata)) begin
                    n_fail++;
                    $display("FAIL sb_xfer: got addr=%h wr=%b lock=%b wdata=%h, required addr=%h wr=%b lock=%b wdata=%h",
                             dp_addr, dp_wr, dp_lock, s_hwdata, e.addr, e.wr, e.lock, e.wdata);
                end
            end
        end
    end

    task automatic idle_inputs();
        for (int n = 0; n < 2; n++) begin
            m_haddr[n]  = '0;
            m_htrans[n] = HTRANS_IDLE;
            m_hsize[n]  = 3'b010;
            m_hburst[n] = 3'b001;
            m_hprot[n]  = 4'b0011;
            m_hwdata[n] = '0;
        end
        m_hwrite     = '0;
        m_hlock      = '0;
        s_hready     = 1'b1;
        s_hresp      = HRESP_OKAY;
        slv_fixed_en = 1'b0;
        slv_fixed    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic put_addr(input int n, input logic [31:0] a, input logic wr, input logic lk);
        m_haddr[n]  = a;
        m_htrans[n] = HTRANS_NONSEQ;
        m_hwrite[n] = wr;
        m_hlock[n]  = lk;
    endtask

    // Pipelined AHB requester: cnt transfers at abase+4i, write data wbase+i.
    task automatic master_seq(input int n, input int cnt, input logic [31:0] abase,
                              input logic wr, input logic lk, input logic [31:0] wbase);
        int          issued;
        int          dp_idx;
        int          guard;
        logic        hr, d_wr;
        logic [31:0] rd, d_a;
        issued = 1;
        dp_idx = -1;
        guard  = 0;
        d_wr   = 1'b0;
        d_a    = '0;
        put_addr(n, abase, wr, lk);
        while (1) begin
            @(negedge clk);
            hr = m_hready[n];
            rd = m_hrdata[n];
            @(posedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                n_checks++; n_fail++;
                $display("FAIL seq_timeout_m%0d: got %0d of %0d issued, required completion", n, issued, cnt);
                m_htrans[n] = HTRANS_IDLE;
                break;
            end
            if (hr) begin
                if (dp_idx >= 0 && !d_wr) begin
                    n_checks++;
                    if (rd !== ~d_a) begin
                        n_fail++;
                        $display("FAIL seq_rdata_m%0d: got %h, required %h", n, rd, ~d_a);
                    end
                end
                if (m_htrans[n][1]) begin
                    dp_idx      = issued - 1;
                    d_a         = m_haddr[n];
                    d_wr        = m_hwrite[n];
                    m_hwdata[n] = wbase + 32'(dp_idx);
                end else begin
                    dp_idx = -1;
                end
                if (issued < cnt) begin
                    put_addr(n, abase + (32'(issued) << 2), wr, lk);
                    issued++;
                end else begin
                    m_htrans[n] = HTRANS_IDLE;
                    m_hlock[n]  = 1'b0;
                end
                if (dp_idx < 0 && m_htrans[n] == HTRANS_IDLE) break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (s_htrans !== HTRANS_IDLE) begin n_fail++; $display("FAIL rst_htrans: got %b, required %b", s_htrans, HTRANS_IDLE); end
        n_checks++; if (s_haddr !== 32'h0) begin n_fail++; $display("FAIL rst_haddr: got %h, required 0", s_haddr); end
        n_checks++; if ({s_hwrite, s_hsize, s_hburst, s_hprot, s_hlock} !== 14'h0) begin
            n_fail++; $display("FAIL rst_ctl: got %b, required 0", {s_hwrite, s_hsize, s_hburst, s_hprot, s_hlock}); end
        n_checks++; if (m_hready !== 2'b11) begin n_fail++; $display("FAIL rst_mready: got %b, required 11", m_hready); end
        n_checks++; if (m_hresp[0] !== HRESP_OKAY || m_hresp[1] !== HRESP_OKAY) begin
            n_fail++; $display("FAIL rst_mresp: got %b/%b, required 00/00", m_hresp[0], m_hresp[1]); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        slv_fixed_en = 1'b1;
        slv_fixed    = 32'hDEAD_BEEF;
        sb.push_back('{addr: 32'h0000_1000, wr: 1'b0, wdata: 32'h0, lock: 1'b0});
        put_addr(0, 32'h0000_1000, 1'b0, 1'b0);
        @(posedge clk); #1;
        m_htrans[0] = HTRANS_IDLE;
        @(negedge clk);
        n_checks++; if (m_hready[0] !== 1'b0) begin n_fail++; $display("FAIL t1_rdy_c1: got %b, required 0", m_hready[0]); end
        n_checks++; if (s_htrans !== HTRANS_IDLE) begin n_fail++; $display("FAIL t1_trans_c1: got %b, required 00", s_htrans); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (s_htrans !== HTRANS_NONSEQ) begin n_fail++; $display("FAIL t1_nseq: got %b, required 10", s_htrans); end
        n_checks++; if (s_haddr !== 32'h0000_1000) begin n_fail++; $display("FAIL t1_haddr: got %h, required 00001000", s_haddr); end
        n_checks++; if (s_hsize !== 3'b010 || s_hprot !== 4'b0011 || s_hburst !== HBURST_SINGLE) begin
            n_fail++; $display("FAIL t1_ctl: got size=%b prot=%b burst=%b, required 010/0011/000", s_hsize, s_hprot, s_hburst); end
        n_checks++; if (m_hready[0] !== 1'b0) begin n_fail++; $display("FAIL t1_rdy_c2: got %b, required 0", m_hready[0]); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (m_hready[0] !== 1'b1) begin n_fail++; $display("FAIL t1_rdy_c3: got %b, required 1", m_hready[0]); end
        n_checks++; if (m_hrdata[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t1_rdata: got %h, required deadbeef", m_hrdata[0]); end
        n_checks++; if (m_hresp[0] !== HRESP_OKAY) begin n_fail++; $display("FAIL t1_hresp: got %b, required 00", m_hresp[0]); end
        @(posedge clk); #1;
        slv_fixed_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        sb.push_back('{addr: 32'h2000_0000, wr: 1'b1, wdata: 32'h1234_5678, lock: 1'b0});
        sb.push_back('{addr: 32'h0000_1000, wr: 1'b0, wdata: 32'h0, lock: 1'b0});
        fork
            master_seq(0, 1, 32'h0000_1000, 1'b0, 1'b0, 32'h0);
            master_seq(1, 1, 32'h2000_0000, 1'b1, 1'b0, 32'h1234_5678);
        join
    endtask

    task automatic test_back_to_back();
        do_reset();
`ifdef FIC0_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 4; i++)
            sb.push_back('{addr: 32'h2000_8000 + 32'(i * 4), wr: 1'b1, wdata: 32'hA000_0000 + 32'(i), lock: 1'b0});
        for (int i = 0; i < 4; i++)
            sb.push_back('{addr: 32'h0000_8000 + 32'(i * 4), wr: 1'b0, wdata: 32'h0, lock: 1'b0});
`else
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{addr: 32'h2000_8000 + 32'(i * 4), wr: 1'b1, wdata: 32'hA000_0000 + 32'(i), lock: 1'b0});
            sb.push_back('{addr: 32'h0000_8000 + 32'(i * 4), wr: 1'b0, wdata: 32'h0, lock: 1'b0});
        end
`endif
        fork
            master_seq(0, 4, 32'h0000_8000, 1'b0, 1'b0, 32'h0);
            master_seq(1, 4, 32'h2000_8000, 1'b1, 1'b0, 32'hA000_0000);
        join
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 3; i++)
            sb.push_back('{addr: 32'h2000_0100 + 32'(i * 4), wr: 1'b1, wdata: 32'hB000_0000 + 32'(i), lock: 1'b1});
        sb.push_back('{addr: 32'h0000_4000, wr: 1'b0, wdata: 32'h0, lock: 1'b0});
        fork
            master_seq(0, 1, 32'h0000_4000, 1'b0, 1'b0, 32'h0);
            master_seq(1, 3, 32'h2000_0100, 1'b1, 1'b1, 32'hB000_0000);
        join
    endtask

    task automatic test_error();
        do_reset();
        sb.push_back('{addr: 32'h0000_7000, wr: 1'b0, wdata: 32'h0, lock: 1'b0});
        put_addr(0, 32'h0000_7000, 1'b0, 1'b0);
        @(posedge clk); #1;
        put_addr(0, 32'h0000_7004, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_hready = 1'b0;
        s_hresp  = HRESP_ERROR;
        @(negedge clk);
        n_checks++; if (m_hready[0] !== 1'b0) begin n_fail++; $display("FAIL err_rdy_c1: got %b, required 0", m_hready[0]); end
        n_checks++; if (m_hresp[0] !== HRESP_ERROR) begin n_fail++; $display("FAIL err_resp_c1: got %b, required 01", m_hresp[0]); end
        @(posedge clk); #1;
        s_hready    = 1'b1;
        m_htrans[0] = HTRANS_IDLE;
        @(negedge clk);
        n_checks++; if (m_hready[0] !== 1'b1) begin n_fail++; $display("FAIL err_rdy_c2: got %b, required 1", m_hready[0]); end
        n_checks++; if (m_hresp[0] !== HRESP_ERROR) begin n_fail++; $display("FAIL err_resp_c2: got %b, required 01", m_hresp[0]); end
        @(posedge clk); #1;
        s_hresp = HRESP_OKAY;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (s_htrans !== HTRANS_IDLE || m_hready[0] !== 1'b1) begin
                n_fail++; $display("FAIL err_nothing_pending: got htrans=%b rdy=%b, required 00/1", s_htrans, m_hready[0]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        put_addr(0, 32'h0000_5000, 1'b0, 1'b0);
        @(posedge clk); #1;
        m_htrans[0] = HTRANS_IDLE;
        s_hready    = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (s_htrans !== HTRANS_NONSEQ) begin n_fail++; $display("FAIL rm_addr_nseq: got %b, required 10", s_htrans); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (s_htrans !== HTRANS_IDLE) begin n_fail++; $display("FAIL rm_addr_abort: got %b, required 00", s_htrans); end
        s_hready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        put_addr(0, 32'h0000_5100, 1'b0, 1'b0);
        put_addr(1, 32'h2000_5100, 1'b1, 1'b0);
        @(posedge clk); #1;
        m_htrans[0] = HTRANS_IDLE;
        m_htrans[1] = HTRANS_IDLE;
        m_hwdata[1] = 32'h5555_AAAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_hready = 1'b0;
        @(negedge clk);
        n_checks++; if (m_hready !== 2'b00) begin n_fail++; $display("FAIL rm_data_stall: got %b, required 00", m_hready); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (m_hready !== 2'b11) begin n_fail++; $display("FAIL rm_data_rdy: got %b, required 11", m_hready); end
        n_checks++; if (s_htrans !== HTRANS_IDLE) begin n_fail++; $display("FAIL rm_data_trans: got %b, required 00", s_htrans); end
        s_hready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (s_htrans !== HTRANS_IDLE || m_hready !== 2'b11) begin
                n_fail++; $display("FAIL rm_cleared: got htrans=%b rdy=%b, required 00/11", s_htrans, m_hready);
            end
        end
        @(posedge clk); #1;
        sb.push_back('{addr: 32'h0000_6000, wr: 1'b0, wdata: 32'h0, lock: 1'b0});
        master_seq(0, 1, 32'h0000_6000, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_lock();
        test_error();
        test_reset_mid();
        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
